ms_uart_tx_gen: RTL
===================

Name: ms_uart_tx_gen

Overview:
Parametrised next-generation UART transmitter for the AHB-UART path.
- Serialises one data word per frame: start bit, 5..DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
- Single clock domain; bit timing driven by a one-cycle TICK enable from the baud generator, never by a derived clock.
- Valid/ready handshake toward the AHB register/FIFO side; per-frame config latched at acceptance.

Parameters:
DATA_W, 8, maximum data bits per frame (>=5).
OVR_HI, 16, TICKs per bit when OVRSEL=0.
OVR_LO, 8, TICKs per bit when OVRSEL=1.
FIFO_DEPTH, 4, entries of optional input FIFO (power of 2, >=2); unused without macro.

Ports:
CLK  in  1  system clock
RESETN  in  1  reset, synchronous, active-high (name kept per codebase; asserted=1)
TICK  in  1  oversample enable, one CLK cycle wide
TX_VALID  in  1  word available
TX_READY  out  1  block accepts word this cycle
DIN  in  DATA_W  word to send
DATASEL  in  2  data bits = DATA_W-3+DATASEL (8-bit default: 5,6,7,8)
PARITYSEL  in  2  00 none, 01 even, 10 odd, 11 mark (constant 1)
STOPSEL  in  1  0 one stop bit, 1 two stop bits
OVRSEL  in  1  0 OVR_HI, 1 OVR_LO
DOUT  out  1  serial line, idle high
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse at end of last stop bit
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  entries held (only with UART_TX_FIFO_EN)

Behaviour:
- Single clock domain: one always block on posedge CLK; TICK is used only as an enable.
- Reset, RESETN=1 at a CLK edge: DOUT=1, BUSY=0, DONE=0, TX_READY=1, state IDLE, bit/tick counters 0.
- Reset mid-frame: frame abandoned; DOUT=1 from the next cycle; no DONE pulse.
- Handshake:
  - Accept when TX_VALID & TX_READY at a CLK edge.
  - TX_READY=1 only in IDLE (without FIFO).
  - On acceptance, latch DIN, DATASEL, PARITYSEL, STOPSEL, OVRSEL; later input changes are ignored until the next acceptance.
- States and transitions:
  - IDLE -> START on acceptance.
  - START -> DATA.
  - DATA -> PARITY if PARITYSEL!=00, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE after 1 or 2 bit periods.
- Bit timing:
  - Each bit holds for exactly OVR TICK pulses, where OVR is the latched OVR_HI or OVR_LO.
  - The tick counter clears on acceptance and on every bit boundary.
  - The state and DOUT change on the CLK edge of the OVR-th TICK.
- Latency: DOUT goes low and BUSY goes high on the cycle after acceptance.
- DATA state: DOUT = data[bitidx], bitidx running 0..N-1, N = DATA_W-3+DATASEL.
- Parity:
  - Computed over the N selected bits only; bits above N-1 are masked.
  - Even: XOR of the selected bits. Odd: inverted XOR. Mark: 1.
- STOP: DOUT=1 for 1 or 2 bit periods.
- DONE: 1 for exactly one cycle on the final TICK of the last stop bit.
  - BUSY falls and TX_READY rises on the same edge; the earliest next acceptance is the following cycle.
- TICK handling:
  - TICK in IDLE is ignored.
  - TICK coincident with acceptance is not counted.
- TX_VALID during a frame: no effect, word held upstream.

Optional Feature:
UART_TX_FIFO_EN:
- Defined: FIFO_DEPTH-entry FIFO between the handshake and the serialiser.
  - Each entry stores DIN plus its config fields.
  - TX_READY = !full.
  - The serialiser pops when in IDLE and the FIFO is non-empty; a word pushed into an empty FIFO starts its frame 1 cycle later than the direct case.
  - Push and pop in the same cycle: level unchanged. Push when full: refused because TX_READY=0.
  - Reset empties the FIFO; FIFO_LEVEL=0.
- Undefined: direct path as above; FIFO_LEVEL port absent.

Decomposition:
- Package ms_uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Parity codes PAR_NONE/EVEN/ODD/MARK.
  - Stop codes.
  - Function computing data-bit count from DATASEL and DATA_W.
- Sub-module ms_uart_tx_fifo: synchronous FIFO, instantiated only under UART_TX_FIFO_EN.

Test Plan:
- DATA_W=8, DIN=0xA5, DATASEL=11, PARITYSEL=00, STOPSEL=0, OVRSEL=0 -> DOUT 0,1,0,1,0,0,1,0,1,1; each bit 16 TICKs; DONE one pulse; 160 TICKs total.
- DIN=0x07, DATASEL=10 (7 bits), PARITYSEL=01 -> parity bit 1. Then PARITYSEL=10 -> parity bit 0. Then PARITYSEL=11 -> 1. Each frame is 10 bits.
- DATASEL=00 (5 bits), DIN=0xFF, STOPSEL=1, OVRSEL=1 -> 5 ones, then 2 stop bits of 8 TICKs each; bits 5..7 never driven; parity (if even) computed over 5 bits = 1.
- Change DIN/config mid-frame; hold TX_VALID high back-to-back -> current frame unchanged; next frame starts exactly 1 cycle after DONE.
- Assert RESETN during DATA bit 3 -> DOUT=1, BUSY=0, TX_READY=1 next cycle; no DONE.
- With UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 words while line busy -> TX_READY low after 4; FIFO_LEVEL 4; all words emitted in order.

Source files
------------

// File: rtl/ms_uart_tx_gen_pkg.sv
// ============================================================================
// Module      : ms_uart_pkg
// Description : Shared state codes, parity/stop codes and the data-bit count
//               helper for the ms_uart_tx_gen transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ms_uart_pkg;

  // Serialiser state codes
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity select codes
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // Stop select codes
  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Width of the per-word config fields stored alongside the data word
  localparam int CFG_W = 6;

  // Number of data bits sent for a given DATASEL: DATA_W-3 .. DATA_W
  function automatic int data_bits(input logic [1:0] datasel, input int data_w);
    return data_w - 3 + int'(datasel);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ms_uart_tx_gen_if.sv
// ============================================================================
// Module      : ms_uart_tx_gen_if
// Description : Valid/ready word handshake plus per-frame config between the
//               AHB register/FIFO side (master) and the transmitter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ms_uart_tx_gen_if #(
  parameter int DATA_W = 8
);
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] DIN;
  logic [1:0]        DATASEL;
  logic [1:0]        PARITYSEL;
  logic              STOPSEL;
  logic              OVRSEL;

  modport master (
    output TX_VALID, DIN, DATASEL, PARITYSEL, STOPSEL, OVRSEL,
    input  TX_READY
  );

  modport slave (
    input  TX_VALID, DIN, DATASEL, PARITYSEL, STOPSEL, OVRSEL,
    output TX_READY
  );
endinterface

`default_nettype wire

// File: rtl/ms_uart_tx_gen_fifo.sv
// ============================================================================
// Module      : ms_uart_tx_fifo
// Description : Small synchronous show-ahead FIFO holding data words with their
//               frame config. Used only when UART_TX_FIFO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_uart_tx_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         pop_data,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on push, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push and pop together leave the level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ms_uart_tx_gen.sv
// ============================================================================
// Module      : ms_uart_tx_gen
// Description : Parametrised UART transmitter. Start bit, 5..DATA_W data bits
//               LSB first, optional parity, 1 or 2 stop bits. Bit timing is
//               counted in TICK enables; config is latched per frame.
//               Optional macro UART_TX_FIFO_EN inserts a FIFO_DEPTH-entry
//               FIFO between the handshake and the serialiser and adds the
//               FIFO_LEVEL output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_uart_tx_gen
  import ms_uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVR_HI     = 16,
  parameter int OVR_LO     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic           CLK,
  input  wire logic           RESETN,
  input  wire logic           TICK,
  ms_uart_tx_gen_if.slave     tx,
  output logic                DOUT,
  output logic                BUSY,
  output logic                DONE
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
`endif
);
  localparam int WORD_W  = DATA_W + CFG_W;
  localparam int IDX_W   = $clog2(DATA_W);
  localparam int OVR_MAX = (OVR_HI > OVR_LO) ? OVR_HI : OVR_LO;
  localparam int TCNT_W  = $clog2(OVR_MAX + 1);

  if (DATA_W < 5 || FIFO_DEPTH < 2) begin : g_bad_param
    $error("ms_uart_tx_gen: DATA_W must be >= 5 and FIFO_DEPTH >= 2");
  end

  state_t              state;
  logic [TCNT_W-1:0]   tick_cnt;
  logic [TCNT_W-1:0]   tick_last;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    nxt_idx;
  logic [IDX_W-1:0]    last_idx;
  logic [DATA_W-1:0]   data;
  logic                par_en;
  logic                par_bit;
  logic                two_stop;
  logic                ovr_lo;
  logic                stop_cnt;
  logic                dout_r;
  logic                done_r;

  logic [WORD_W-1:0]   in_word;
  logic [WORD_W-1:0]   src_word;
  logic                src_valid;
  logic                start;
  logic [DATA_W-1:0]   src_din;
  logic [1:0]          src_dsel;
  logic [1:0]          src_psel;
  logic                src_stop;
  logic                src_ovr;
  logic [IDX_W-1:0]    src_last;
  logic                src_xor;
  logic                src_par;

  assign in_word = {tx.DIN, tx.DATASEL, tx.PARITYSEL, tx.STOPSEL, tx.OVRSEL};

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  assign tx.TX_READY = !fifo_full;
  assign src_valid   = !fifo_empty;

  ms_uart_tx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESETN),
    .push      (tx.TX_VALID && !fifo_full),
    .push_data (in_word),
    .pop       (start),
    .pop_data  (src_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (FIFO_LEVEL)
  );
`else
  assign tx.TX_READY = (state == ST_IDLE);
  assign src_valid   = tx.TX_VALID;
  assign src_word    = in_word;
`endif

  // A frame starts whenever the serialiser is idle and a word is offered
  assign start = (state == ST_IDLE) && src_valid;

  assign src_din  = src_word[WORD_W-1:CFG_W];
  assign src_dsel = src_word[5:4];
  assign src_psel = src_word[3:2];
  assign src_stop = src_word[1];
  assign src_ovr  = src_word[0];

  assign tick_last = src_ovr_sel_last(ovr_lo);
  assign nxt_idx   = bit_idx + 1'b1;
  assign DOUT      = dout_r;
  assign DONE      = done_r;
  assign BUSY      = (state != ST_IDLE);

  function automatic logic [TCNT_W-1:0] src_ovr_sel_last(input logic lo);
    return lo ? TCNT_W'(OVR_LO - 1) : TCNT_W'(OVR_HI - 1);
  endfunction

  // Parity of the offered word over its selected bits only; upper bits masked
  always_comb begin
    src_last = IDX_W'(data_bits(src_dsel, DATA_W) - 1);
    src_xor  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i <= int'(src_last)) begin
        src_xor = src_xor ^ src_din[i];
      end
    end
    case (src_psel)
      PAR_EVEN: src_par = src_xor;
      PAR_ODD:  src_par = ~src_xor;
      PAR_MARK: src_par = 1'b1;
      default:  src_par = 1'b1;
    endcase
  end

  // Frame sequencer: latch word on start, advance one bit every OVR ticks
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state    <= ST_IDLE;
      dout_r   <= 1'b1;
      done_r   <= 1'b0;
      tick_cnt <= '0;
      bit_idx  <= '0;
      last_idx <= '0;
      stop_cnt <= 1'b0;
      data     <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      ovr_lo   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == ST_IDLE) begin
        // Ticks in idle, including one coincident with acceptance, are not counted
        if (start) begin
          data     <= src_din;
          last_idx <= src_last;
          par_en   <= (src_psel != PAR_NONE);
          par_bit  <= src_par;
          two_stop <= src_stop;
          ovr_lo   <= src_ovr;
          tick_cnt <= '0;
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
          dout_r   <= 1'b0;
          state    <= ST_START;
        end
      end else if (TICK) begin
        if (tick_cnt != tick_last) begin
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          tick_cnt <= '0;
          case (state)
            ST_START: begin
              state   <= ST_DATA;
              bit_idx <= '0;
              dout_r  <= data[0];
            end
            ST_DATA: begin
              if (bit_idx == last_idx) begin
                if (par_en) begin
                  state  <= ST_PARITY;
                  dout_r <= par_bit;
                end else begin
                  state  <= ST_STOP;
                  dout_r <= 1'b1;
                end
              end else begin
                bit_idx <= nxt_idx;
                dout_r  <= data[nxt_idx];
              end
            end
            ST_PARITY: begin
              state  <= ST_STOP;
              dout_r <= 1'b1;
            end
            ST_STOP: begin
              dout_r <= 1'b1;
              if (two_stop == STOP_ONE || stop_cnt == STOP_TWO) begin
                state  <= ST_IDLE;
                done_r <= 1'b1;
              end else begin
                stop_cnt <= 1'b1;
              end
            end
            default: begin
              state  <= ST_IDLE;
              dout_r <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire
